// File: rtl/fcfs_queue_arbiter.sv
// First-come-first-served arbiter: arrival-order index queue feeding a registered one-hot grant,
// with burst-limit preemption and a mandatory idle cycle between owners.
module fcfs_queue_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8,
  parameter int IDW       = $clog2(NREQ),
  parameter int CW        = $clog2(MAX_BURST) + 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_id,
  output logic [IDW:0]    queue_count
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t          r_state, w_state_nx;
  logic [IDW-1:0]  r_q [NREQ];
  logic [IDW-1:0]  w_q_nx [NREQ];
  logic [NREQ-1:0] r_pending, w_pending_nx;
  logic [IDW:0]    r_count, w_count_nx, w_tail;
  logic [NREQ-1:0] r_grant, w_grant_nx;
  logic            r_valid, w_valid_nx;
  logic [IDW-1:0]  r_id, w_id_nx;
  logic [CW-1:0]   r_burst, w_burst_nx;
  logic [NREQ-1:0] w_enq;
  logic            w_pop, w_preempt;
  logic [IDW-1:0]  w_head;

  assign w_head = r_q[0];

  // A requester is a new arrival only if it is neither queued nor the current owner.
  always_comb begin
    w_enq = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_enq[i] = req[i] && !r_pending[i] && !(r_state == S_GRANT && r_id == IDW'(i));
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_valid_nx = r_valid;
    w_id_nx    = r_id;
    w_burst_nx = r_burst;
    w_pop      = 1'b0;
    w_preempt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          // A head that withdrew while queued is simply dropped; that costs this cycle.
          if (req[w_head]) begin
            w_state_nx = S_GRANT;
            w_grant_nx = NREQ'(1) << w_head;
            w_valid_nx = 1'b1;
            w_id_nx    = w_head;
            w_burst_nx = CW'(1);
          end
        end
      end
      S_GRANT: begin
        if (!req[r_id] || (r_burst == CW'(MAX_BURST) && r_count != '0)) begin
          w_preempt  = req[r_id];
          w_state_nx = S_IDLE;
          w_grant_nx = '0;
          w_valid_nx = 1'b0;
          w_id_nx    = '0;
          w_burst_nx = '0;
        end else if (r_burst != CW'(MAX_BURST)) begin
          w_burst_nx = r_burst + CW'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Queue update order: pop head, append arrivals by ascending index, then the preempted owner.
  always_comb begin
    w_q_nx       = r_q;
    w_pending_nx = r_pending;
    w_tail       = r_count;
    if (w_pop) begin
      for (int k = 0; k < NREQ - 1; k++) begin
        w_q_nx[k] = r_q[k+1];
      end
      w_q_nx[NREQ-1]       = '0;
      w_pending_nx[w_head] = 1'b0;
      w_tail               = r_count - (IDW+1)'(1);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_enq[i]) begin
        w_q_nx[w_tail[IDW-1:0]] = IDW'(i);
        w_pending_nx[i]         = 1'b1;
        w_tail                  = w_tail + (IDW+1)'(1);
      end
    end
    if (w_preempt) begin
      w_q_nx[w_tail[IDW-1:0]] = r_id;
      w_pending_nx[r_id]      = 1'b1;
      w_tail                  = w_tail + (IDW+1)'(1);
    end
    w_count_nx = w_tail;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_count   <= '0;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_burst   <= '0;
      for (int k = 0; k < NREQ; k++) begin
        r_q[k] <= '0;
      end
    end else begin
      r_state   <= w_state_nx;
      r_pending <= w_pending_nx;
      r_count   <= w_count_nx;
      r_grant   <= w_grant_nx;
      r_valid   <= w_valid_nx;
      r_id      <= w_id_nx;
      r_burst   <= w_burst_nx;
      for (int k = 0; k < NREQ; k++) begin
        r_q[k] <= w_q_nx[k];
      end
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_valid;
  assign grant_id    = r_id;
  assign queue_count = r_count;

endmodule

// File: tb/tb_fcfs_queue_arbiter.sv
// Bench for fcfs_queue_arbiter: directed literal schedules plus random traffic against a queue-level model.
module tb_fcfs_queue_arbiter;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 8;
  localparam int IDW       = 2;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] grant;
  logic            grant_valid;
  logic [IDW-1:0]  grant_id;
  logic [IDW:0]    queue_count;

  always #5 clk = ~clk;

  fcfs_queue_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .resetn(resetn), .req(req), .grant(grant),
    .grant_valid(grant_valid), .grant_id(grant_id), .queue_count(queue_count)
  );

  int total = 0;
  int bad = 0;

  // Model state: FIFO of waiting indices, pending flags, owner (-1 = none), grant cycles used.
  int mq[$];
  bit mpend[NREQ];
  int mown = -1;
  int mburst = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int arr[$];
    int qlen0, nown, pre, h;
    chk_en = 1'b1;
    if (!resetn) begin
      mq.delete();
      for (int i = 0; i < NREQ; i++) mpend[i] = 1'b0;
      mown = -1;
      mburst = 0;
    end else begin
      arr.delete();
      for (int i = 0; i < NREQ; i++)
        if (req[i] && !mpend[i] && i != mown) arr.push_back(i);
      qlen0 = mq.size();
      nown = mown;
      pre = -1;
      if (mown < 0) begin
        if (qlen0 > 0) begin
          h = mq.pop_front();
          mpend[h] = 1'b0;
          if (req[h]) begin
            nown = h;
            mburst = 1;
          end
        end
      end else if (!req[mown]) begin
        nown = -1;
      end else if (mburst == MAX_BURST && qlen0 > 0) begin
        pre = mown;
        nown = -1;
      end else if (mburst < MAX_BURST) begin
        mburst++;
      end
      foreach (arr[j]) begin
        mq.push_back(arr[j]);
        mpend[arr[j]] = 1'b1;
      end
      if (pre >= 0) begin
        mq.push_back(pre);
        mpend[pre] = 1'b1;
      end
      mown = nown;
    end
  end

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] eg;
    if (chk_en) begin
      eg = (mown >= 0) ? (NREQ'(1) << mown) : '0;
      chk("grant", grant, eg);
      chk("grant_valid", grant_valid, mown >= 0);
      chk("grant_id", grant_id, (mown >= 0) ? mown : 0);
      chk("queue_count", queue_count, mq.size());
      chk("count_le_nreq", queue_count <= NREQ, 1);
    end
  end

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    nc();
    req = '0;
    resetn = 1'b0;
    nc();
    nc();
    resetn = 1'b1;
  endtask

  function automatic logic [3:0] exp_d(input int c);
    if (c >= 2 && c <= 9) return 4'b0010;
    if (c >= 11 && c <= 18) return 4'b1000;
    if (c >= 20) return 4'b0010;
    return 4'b0000;
  endfunction

  initial begin
    int last;
    int n;
    logic [3:0] ec;
    // Requests held through reset, then served in index order
    resetn = 1'b0;
    req = 4'b1111;
    nc(); nc(); nc();
    chk("A_rst_grant", grant, 0);
    chk("A_rst_count", queue_count, 0);
    resetn = 1'b1;
    nc();
    chk("A_count4", queue_count, 4);
    last = -1;
    for (int e = 0; e < 4; e++) begin
      n = 0;
      while (!(grant_valid === 1'b1 && grant_id != last) && n < 60) begin
        nc();
        n++;
      end
      chk("A_order", (n < 60) ? grant_id : 99, e);
      last = grant_id;
    end

    // Single requester, held cycles 0..9
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      nc();
      chk("B_grant", grant, (c >= 2 && c <= 10) ? 4'b0010 : 4'b0000);
      if (c >= 2 && c <= 10) chk("B_id", grant_id, 1);
      req = (c <= 9) ? 4'b0010 : 4'b0000;
    end

    // Staggered arrivals 2,0,3 each holding three grant cycles
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      nc();
      if (c >= 2 && c <= 4) ec = 4'b0100;
      else if (c >= 6 && c <= 8) ec = 4'b0001;
      else if (c >= 10 && c <= 12) ec = 4'b1000;
      else ec = 4'b0000;
      chk("C_grant", grant, ec);
      req = {c >= 2 && c <= 11, c >= 0 && c <= 3, 1'b0, c >= 1 && c <= 7};
    end

    // Simultaneous 3 and 1, both held: burst-limited alternation
    do_reset();
    for (int c = 0; c <= 21; c++) begin
      nc();
      chk("D_grant", grant, exp_d(c));
      req = 4'b1010;
    end

    // Lone requester is never preempted
    do_reset();
    for (int c = 0; c <= 52; c++) begin
      nc();
      if (c >= 2) chk("D_lone", grant, 4'b0001);
      req = 4'b0001;
    end

    // Queued requester withdraws before its turn
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      nc();
      chk("E_no_grant2", grant[2], 0);
      if (c == 4) chk("E_count1", queue_count, 1);
      if (c == 6) chk("E_grant0", grant, 4'b0001);
      if (c == 7) chk("E_skip_idle", grant, 4'b0000);
      if (c == 8) chk("E_count0", queue_count, 0);
      if (c < 3) req = 4'b0001;
      else if (c < 5) req = 4'b0101;
      else if (c < 6) req = 4'b0001;
      else req = 4'b0000;
    end

    // Reset mid-grant with two waiting, then ascending re-enqueue
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      nc();
      if (c == 3) begin
        chk("F_pre_count", queue_count, 2);
        chk("F_pre_grant", grant, 4'b0001);
      end
      if (c == 4) begin
        chk("F_rst_grant", grant, 0);
        chk("F_rst_count", queue_count, 0);
      end
      if (c == 5) chk("F_count3", queue_count, 3);
      if (c == 6) chk("F_first", grant, 4'b0001);
      if (c == 15) chk("F_second", grant, 4'b0010);
      if (c == 24) chk("F_third", grant, 4'b0100);
      req = 4'b0111;
      resetn = (c == 3) ? 1'b0 : 1'b1;
    end

    // Random traffic with occasional resets
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      nc();
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      resetn = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
    end

    nc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
